// File: rtl/mtr_drv_pkg.sv
// mtr_drv_pkg: shared PWM width, channel FSM state type and speed-to-magnitude helper
package mtr_drv_pkg;

    localparam int PWM_W = 11;

    typedef enum logic {DRIVE, COAST} chan_state_t;

    // |spd| at 12 bits; only -2048 overflows 11 bits and is clamped to full scale
    function automatic logic [PWM_W-1:0] spd_to_mag(input logic signed [11:0] spd);
        logic [11:0] a;
        a = spd[11] ? -spd : spd;
        return a[11] ? {PWM_W{1'b1}} : a[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/mtr_chan.sv
// mtr_chan: one H-bridge channel - duty/direction FSM with reversal coast and registered PWM pair
//   clk, rst_n : clock, synchronous active-low reset
//   bnd_i      : high in the cycle cnt_i == 2047 (period boundary edge)
//   cnt_i      : shared PWM timebase
//   spd_i      : signed speed command, sampled only at the boundary
//   ovr_i      : over-current sample, present only when OVR_CURR_EN is defined
//   fwd_o/rev_o: registered forward/reverse drive
module mtr_chan
    import mtr_drv_pkg::*;
#(
    parameter int REV_COAST_PER = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bnd_i,
    input  logic [PWM_W-1:0]   cnt_i,
    input  logic signed [11:0] spd_i,
`ifdef OVR_CURR_EN
    input  logic               ovr_i,
`endif
    output logic               fwd_o,
    output logic               rev_o
);

    localparam logic [1:0] CC_INIT = 2'(REV_COAST_PER - 1);

    chan_state_t      state_q, state_d;
    logic [PWM_W-1:0] duty_q, duty_d, mag;
    logic [1:0]       cc_q, cc_d;
    logic             dir_q, dir_d, dir_new;
    logic             fwd_q, fwd_d, rev_q, rev_d;
    logic             blank, on;

`ifdef OVR_CURR_EN
    logic blank_q, blank_d;

    // The sample itself gates the very next output; the latch holds it until the boundary
    always_comb begin
        blank   = ovr_i | blank_q;
        blank_d = bnd_i ? 1'b0 : blank;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) blank_q <= 1'b0;
        else        blank_q <= blank_d;
    end
`else
    always_comb blank = 1'b0;
`endif

    always_comb begin
        mag     = spd_to_mag(spd_i);
        dir_new = spd_i[11];
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        cc_d    = cc_q;
        if (bnd_i) begin
            // Reversal while actually driving: force idle periods before flipping the bridge
            if (state_q == DRIVE && mag != '0 && duty_q != '0 && dir_new != dir_q) begin
                state_d = COAST;
                duty_d  = '0;
                cc_d    = CC_INIT;
            end else if (state_q == COAST && cc_q != '0) begin
                cc_d = cc_q - 2'd1;
            end else begin
                state_d = DRIVE;
                duty_d  = mag;
                dir_d   = dir_new;
            end
        end
        on    = state_q == DRIVE && cnt_i < duty_q && !blank;
        fwd_d = on && !dir_q;
        rev_d = on && dir_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DRIVE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            cc_q    <= '0;
            fwd_q   <= 1'b0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            cc_q    <= cc_d;
            fwd_q   <= fwd_d;
            rev_q   <= rev_d;
        end
    end

    assign fwd_o = fwd_q;
    assign rev_o = rev_q;

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: dual-channel motor PWM driver with shared 11-bit timebase and reversal coast interlock
//   clk, rst_n          : clock, synchronous active-low reset
//   lft_spd, rgt_spd    : signed 12-bit wheel speed commands
//   ovr_I_lft/ovr_I_rght: per-channel over-current inputs (only with OVR_CURR_EN defined)
//   PWM_frwrd_*/PWM_rev_*: H-bridge drive outputs
//   prd_sync            : registered pulse, high in the cycle the timebase is 0
// Optional feature macro: OVR_CURR_EN (cycle-by-cycle current-limit blanking)
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int REV_COAST_PER = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rgt_spd,
`ifdef OVR_CURR_EN
    input  logic               ovr_I_lft,
    input  logic               ovr_I_rght,
`endif
    output logic               PWM_frwrd_lft,
    output logic               PWM_rev_lft,
    output logic               PWM_frwrd_rght,
    output logic               PWM_rev_rght,
    output logic               prd_sync
);

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic             bnd;

    always_comb begin
        bnd   = &cnt_q;
        cnt_d = cnt_q + PWM_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            prd_sync <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            prd_sync <= bnd;
        end
    end

    mtr_chan #(.REV_COAST_PER(REV_COAST_PER)) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .bnd_i (bnd),
        .cnt_i (cnt_q),
        .spd_i (lft_spd),
`ifdef OVR_CURR_EN
        .ovr_i (ovr_I_lft),
`endif
        .fwd_o (PWM_frwrd_lft),
        .rev_o (PWM_rev_lft)
    );

    mtr_chan #(.REV_COAST_PER(REV_COAST_PER)) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .bnd_i (bnd),
        .cnt_i (cnt_q),
        .spd_i (rgt_spd),
`ifdef OVR_CURR_EN
        .ovr_i (ovr_I_rght),
`endif
        .fwd_o (PWM_frwrd_rght),
        .rev_o (PWM_rev_rght)
    );

endmodule
